// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the program-counter sequencer.
//   br_cond_e            branch condition codes (funct3 encoding)
//   DEFAULT_RESET_VECTOR PC loaded on reset unless overridden
//   branch_taken()       resolves a condition code against the ALU flags
package pc_pkg;

    typedef enum logic [2:0] {
        BrEq  = 3'b000,  // taken on zero
        BrNe  = 3'b001,  // taken on not zero
        BrRs2 = 3'b010,  // reserved, never taken
        BrRs3 = 3'b011,  // reserved, never taken
        BrLt  = 3'b100,  // taken on negative
        BrGe  = 3'b101,  // taken on not negative
        BrLtu = 3'b110,  // taken on carry
        BrGeu = 3'b111   // taken on not carry
    } br_cond_e;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    function automatic logic branch_taken(input logic [2:0] cond, input logic zero,
                                          input logic neg, input logic carry);
        logic taken;
        taken = 1'b0;
        case (cond)
            BrEq:    taken = zero;
            BrNe:    taken = !zero;
            BrLt:    taken = neg;
            BrGe:    taken = !neg;
            BrLtu:   taken = carry;
            BrGeu:   taken = !carry;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack.
//   clk, reset  clock and synchronous active-high reset (clears occupancy)
//   push, pop   push din / pop top; both on a non-empty stack replaces the top
//   din, dout   entry to push / current top entry
//   empty, full occupancy status derived from the registered count
// A push onto a full stack overwrites the oldest entry; the count saturates.
module pc_ras #(
    parameter int unsigned RAS_DEPTH = 4,
    parameter int unsigned XLEN      = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] din,
    output logic [XLEN-1:0] dout,
    output logic            empty,
    output logic            full
);

    localparam int unsigned PtrW = $clog2(RAS_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [XLEN-1:0] mem_q [RAS_DEPTH];
    logic [PtrW-1:0] top_q;
    logic [CntW-1:0] cnt_q;

    assign dout  = mem_q[top_q];
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CntW'(RAS_DEPTH));

    always_ff @(posedge clk) begin
        if (reset) begin
            top_q <= '0;
            cnt_q <= '0;
        end else if (push && pop && !empty) begin
            mem_q[top_q] <= din;
        end else if (pop && !empty) begin
            top_q <= top_q - PtrW'(1);
            cnt_q <= cnt_q - CntW'(1);
        end else if (push) begin
            // Pointer wraps, so a full stack silently drops its oldest entry.
            top_q                  <= top_q + PtrW'(1);
            mem_q[top_q + PtrW'(1)] <= din;
            if (!full) begin
                cnt_q <= cnt_q + CntW'(1);
            end
        end
    end

endmodule

// File: rtl/pc_seq.sv
// pc_seq: program-counter sequencer with return-address stack and
// misaligned-target trap.
//   CLK, Reset           clock, synchronous active-high reset
//   stall                hold PC and RAS
//   jmpFlag/jmpAddress   absolute jump
//   branchFlag/branchCond/zeroFlag/negFlag/carryFlag/branchOffset  relative branch
//   rasPush, rasPop      call/return hints
//   addr, retAddr        current PC and PC+4
//   rasEmpty, rasFull    stack occupancy
//   misalign             sticky trap, cleared only by Reset
//   resetControl         high during Reset and one cycle after it
module pc_seq import pc_pkg::*; #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
    parameter int unsigned     RAS_DEPTH    = 4
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic            stall,
    input  logic            jmpFlag,
    input  logic [XLEN-1:0] jmpAddress,
    input  logic            branchFlag,
    input  logic [2:0]      branchCond,
    input  logic            zeroFlag,
    input  logic            negFlag,
    input  logic            carryFlag,
    input  logic [XLEN-1:0] branchOffset,
    input  logic            rasPush,
    input  logic            rasPop,
    output logic [XLEN-1:0] addr,
    output logic [XLEN-1:0] retAddr,
    output logic            rasEmpty,
    output logic            rasFull,
    output logic            misalign,
    output logic            resetControl
);

    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] ras_top;
    logic            misalign_q, misalign_d;
    logic            reset_dly_q;
    logic            advance;
    logic            bad_target;
    logic            ras_push, ras_pop;

    assign addr         = addr_q;
    assign retAddr      = addr_q + XLEN'(4);
    assign misalign     = misalign_q;
    assign resetControl = Reset | reset_dly_q;

    always_comb begin
        target = retAddr;
        if (jmpFlag) begin
            target = jmpAddress;
        end else if (rasPop && !rasEmpty) begin
            target = ras_top;
        end else if (branchFlag && branch_taken(branchCond, zeroFlag, negFlag, carryFlag)) begin
            target = addr_q + branchOffset;
        end

        bad_target = (target[1:0] != 2'b00);
        advance    = !misalign_q && !stall;

        addr_d     = addr_q;
        misalign_d = misalign_q;
        if (advance) begin
            if (bad_target) begin
                misalign_d = 1'b1;
            end else begin
                addr_d = target;
            end
        end

        // Stack updates only commit alongside a PC update that actually loads.
        ras_push = advance && !bad_target && rasPush;
        ras_pop  = advance && !bad_target && rasPop && !rasEmpty;
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            addr_q     <= RESET_VECTOR;
            misalign_q <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            misalign_q <= misalign_d;
        end
        reset_dly_q <= Reset;
    end

    pc_ras #(
        .RAS_DEPTH (RAS_DEPTH),
        .XLEN      (XLEN)
    ) u_ras (
        .clk   (CLK),
        .reset (Reset),
        .push  (ras_push),
        .pop   (ras_pop),
        .din   (retAddr),
        .dout  (ras_top),
        .empty (rasEmpty),
        .full  (rasFull)
    );

endmodule

// File: tb/tb_pc_seq.sv
module tb_pc_seq;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RV    = 32'h0000_0000;

    logic        CLK = 1'b0;
    logic        Reset, stall, jmpFlag, branchFlag, zeroFlag, negFlag, carryFlag;
    logic        rasPush, rasPop;
    logic [2:0]  branchCond;
    logic [31:0] jmpAddress, branchOffset;
    logic [31:0] addr, retAddr;
    logic        rasEmpty, rasFull, misalign, resetControl;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 CLK = ~CLK;

    pc_seq #(
        .XLEN         (XLEN),
        .RESET_VECTOR (RV),
        .RAS_DEPTH    (DEPTH)
    ) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .stall        (stall),
        .jmpFlag      (jmpFlag),
        .jmpAddress   (jmpAddress),
        .branchFlag   (branchFlag),
        .branchCond   (branchCond),
        .zeroFlag     (zeroFlag),
        .negFlag      (negFlag),
        .carryFlag    (carryFlag),
        .branchOffset (branchOffset),
        .rasPush      (rasPush),
        .rasPop       (rasPop),
        .addr         (addr),
        .retAddr      (retAddr),
        .rasEmpty     (rasEmpty),
        .rasFull      (rasFull),
        .misalign     (misalign),
        .resetControl (resetControl)
    );

    // ---------------- behavioural model ----------------
    logic [31:0] m_addr;
    bit          m_mis;
    bit          m_rdly;
    logic [31:0] m_stack[$];  // back = top of stack

    function automatic bit cond_taken(input logic [2:0] c, input logic z, input logic n,
                                      input logic cy);
        case (c)
            3'd0: return z;
            3'd1: return !z;
            3'd4: return n;
            3'd5: return !n;
            3'd6: return cy;
            3'd7: return !cy;
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge CLK) begin : model
        logic [31:0] tgt;
        logic [31:0] ret;
        if (Reset) begin
            m_addr = RV;
            m_mis  = 1'b0;
            m_stack.delete();
        end else if (!m_mis && !stall) begin
            ret = m_addr + 32'd4;
            tgt = ret;
            if (jmpFlag) tgt = jmpAddress;
            else if (rasPop && m_stack.size() > 0) tgt = m_stack[m_stack.size()-1];
            else if (branchFlag && cond_taken(branchCond, zeroFlag, negFlag, carryFlag))
                tgt = m_addr + branchOffset;
            if (tgt[1:0] != 2'b00) begin
                m_mis = 1'b1;
            end else begin
                if (rasPop && m_stack.size() > 0) void'(m_stack.pop_back());
                if (rasPush) begin
                    m_stack.push_back(ret);
                    if (m_stack.size() > DEPTH) void'(m_stack.pop_front());
                end
                m_addr = tgt;
            end
        end
        m_rdly = Reset;
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge CLK) begin
        if (chk_en) begin
            cmp("addr", addr, m_addr);
            cmp("retAddr", retAddr, m_addr + 32'd4);
            cmp("rasEmpty", {31'd0, rasEmpty}, {31'd0, m_stack.size() == 0});
            cmp("rasFull", {31'd0, rasFull}, {31'd0, m_stack.size() == DEPTH});
            cmp("misalign", {31'd0, misalign}, {31'd0, m_mis});
            cmp("resetControl", {31'd0, resetControl}, {31'd0, Reset | m_rdly});
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge CLK);
        @(negedge CLK);
        #1;
    endtask

    task automatic idle();
        Reset = 0; stall = 0; jmpFlag = 0; branchFlag = 0; rasPush = 0; rasPop = 0;
        zeroFlag = 0; negFlag = 0; carryFlag = 0; branchCond = 3'd2;
        jmpAddress = '0; branchOffset = '0;
    endtask

    task automatic jmp_to(input logic [31:0] a, input bit push);
        jmpFlag = 1; jmpAddress = a; rasPush = push;
        cyc();
        jmpFlag = 0; rasPush = 0;
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp(name, act, exp);
    endtask

    initial begin
        idle();
        Reset = 1;
        cyc();
        chk_en = 1'b1;
        cyc();
        lit("rst_addr", addr, 32'h0);
        lit("rst_ret", retAddr, 32'h4);
        lit("rst_empty", {31'd0, rasEmpty}, 32'd1);
        lit("rst_full", {31'd0, rasFull}, 32'd0);
        lit("rst_ctl", {31'd0, resetControl}, 32'd1);
        Reset = 0;
        #1;
        lit("rst_ctl_tail", {31'd0, resetControl}, 32'd1);
        cyc();
        lit("seq4", addr, 32'h4);
        lit("rst_ctl_off", {31'd0, resetControl}, 32'd0);
        cyc();
        lit("seq8", addr, 32'h8);
        cyc();
        lit("seq12", addr, 32'hC);

        // Branch taken / not taken from 0x10.
        jmp_to(32'h10, 0);
        branchFlag = 1; branchCond = 3'b000; zeroFlag = 1; branchOffset = 32'hFFFF_FFF8;
        cyc();
        lit("beq_taken", addr, 32'h8);
        branchFlag = 0;
        jmp_to(32'h10, 0);
        branchFlag = 1; branchCond = 3'b001;
        cyc();
        lit("bne_fall", addr, 32'h14);
        branchFlag = 0; zeroFlag = 0;

        // Fill RAS past its depth, then drain.
        jmp_to(32'h100, 0);
        jmp_to(32'h200, 1);
        jmp_to(32'h300, 1);
        jmp_to(32'h400, 1);
        jmp_to(32'h500, 1);
        jmp_to(32'h600, 1);
        lit("ras_full", {31'd0, rasFull}, 32'd1);
        rasPop = 1;
        cyc(); lit("pop1", addr, 32'h504);
        cyc(); lit("pop2", addr, 32'h404);
        cyc(); lit("pop3", addr, 32'h304);
        cyc(); lit("pop4", addr, 32'h204);
        lit("ras_empty", {31'd0, rasEmpty}, 32'd1);
        cyc(); lit("pop5_fall", addr, 32'h208);
        rasPop = 0;

        // Stall blocks jump and push.
        stall = 1; jmpFlag = 1; jmpAddress = 32'h800; rasPush = 1;
        cyc();
        lit("stall_hold", addr, 32'h208);
        lit("stall_ras", {31'd0, rasEmpty}, 32'd1);
        stall = 0; rasPush = 0;
        cyc();
        lit("stall_rel", addr, 32'h800);
        jmpFlag = 0;

        // Misaligned jump traps and sticks.
        jmp_to(32'h0FFE, 0);
        lit("mis_hold", addr, 32'h800);
        lit("mis_set", {31'd0, misalign}, 32'd1);
        jmp_to(32'h1000, 0);
        lit("mis_sticky", addr, 32'h800);
        Reset = 1;
        cyc();
        Reset = 0;
        lit("mis_clr", {31'd0, misalign}, 32'd0);
        lit("mis_rst_addr", addr, 32'h0);

        // Randomized phase; the every-cycle compare does the checking.
        for (int i = 0; i < 4000; i++) begin
            Reset        = ($urandom_range(0, 99) < (misalign ? 20 : 1));
            stall        = ($urandom_range(0, 5) == 0);
            jmpFlag      = ($urandom_range(0, 7) == 0);
            jmpAddress   = {$urandom_range(0, 4095), 2'b00};
            if ($urandom_range(0, 15) == 0) jmpAddress[1:0] = 2'($urandom_range(1, 3));
            branchFlag   = ($urandom_range(0, 2) == 0);
            branchCond   = 3'($urandom_range(0, 7));
            zeroFlag     = 1'($urandom);
            negFlag      = 1'($urandom);
            carryFlag    = 1'($urandom);
            branchOffset = 32'($signed($urandom_range(0, 511)) - 256) <<< 2;
            if ($urandom_range(0, 31) == 0) branchOffset[0] = 1'b1;
            rasPush      = ($urandom_range(0, 3) == 0);
            rasPop       = ($urandom_range(0, 3) == 0);
            cyc();
        end

        idle();
        cyc();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
